fifo_burst_drain: RTL

- Downstream consumer of the team's simple FIFO; sits directly on its read side.
- Pops words through the FIFO's re/dout/empty interface.
- Re-emits the words as a valid/ready stream framed into bursts: out_last is set every BURST beats, or on the final buffered word once the FIFO has stayed empty for TIMEOUT cycles, or on a host flush.
- One word is always held back, so out_last can be attached to it retroactively.

---
 rtl/fifo_burst_drain.sv | 113 +++++++++++
 1 files changed

// File: rtl/fifo_burst_drain.sv
// Drains the simple FIFO into a valid/ready stream framed into BURST-beat bursts.
// Define FIFO_BURST_DRAIN_FRAME_CNT_EN to add the frame_cnt/timeout_cnt statistics outputs.
module fifo_burst_drain #(
    parameter int WIDTH   = 32,
    parameter int BURST   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_dout,
    output logic             fifo_re,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic [15:0]      beat_cnt
`ifdef FIFO_BURST_DRAIN_FRAME_CNT_EN
    ,
    output logic [31:0]      frame_cnt,
    output logic [15:0]      timeout_cnt
`endif
);
    localparam int            IW        = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [15:0]   LAST_BEAT = 16'(BURST - 1);
    localparam logic [IW-1:0] IDLE_MAX  = IW'(TIMEOUT);

    logic [WIDTH-1:0] hold_data;
    logic             hold_valid;
    logic             hold_last;
    logic [IW-1:0]    idle_cnt;

    logic out_free;
    logic burst_end;
    logic timeout_hit;
    logic final_w;
    logic release_if_pop;
    logic pop;
    logic rel;

    assign out_free       = !out_valid || out_ready;
    assign burst_end      = (beat_cnt == LAST_BEAT);
    assign timeout_hit    = (TIMEOUT != 0) && (idle_cnt == IDLE_MAX);
    // A flush arriving this cycle closes the held word immediately, even when a pop coincides.
    assign final_w        = hold_last || flush || burst_end || timeout_hit;
    assign release_if_pop = hold_valid && out_free;
    assign fifo_re        = !fifo_empty && (!hold_valid || release_if_pop);
    assign pop            = fifo_re;
    assign rel            = hold_valid && out_free && (final_w || pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_data  <= '0;
            hold_valid <= 1'b0;
            hold_last  <= 1'b0;
        end else if (pop) begin
            hold_data  <= fifo_dout;
            hold_valid <= 1'b1;
            hold_last  <= 1'b0;
        end else if (rel) begin
            hold_valid <= 1'b0;
            hold_last  <= 1'b0;
        end else if (flush && hold_valid) begin
            hold_last  <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            idle_cnt <= '0;
        else if (pop || !hold_valid)
            idle_cnt <= '0;
        else if (fifo_empty && (idle_cnt != IDLE_MAX))
            idle_cnt <= idle_cnt + IW'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            beat_cnt  <= '0;
        end else if (rel) begin
            out_data  <= hold_data;
            out_valid <= 1'b1;
            out_last  <= final_w;
            beat_cnt  <= final_w ? 16'd0 : beat_cnt + 16'd1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end
    end

`ifdef FIFO_BURST_DRAIN_FRAME_CNT_EN
    // Only frames closed purely by the idle timer count as timeouts.
    logic timeout_only;
    assign timeout_only = rel && timeout_hit && !hold_last && !flush && !burst_end;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_cnt   <= '0;
            timeout_cnt <= '0;
        end else begin
            if (out_valid && out_ready && out_last)
                frame_cnt <= frame_cnt + 32'd1;
            if (timeout_only && (timeout_cnt != 16'hFFFF))
                timeout_cnt <= timeout_cnt + 16'd1;
        end
    end
`endif

endmodule
